// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the pipeline and the iterative multiply/divide unit
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv.sv
// muldiv: 32-bit MIPS-style HI/LO unit; one bit per cycle shift-add multiply and restoring divide
module muldiv (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] m;
  logic        is_div, neg_q, neg_r;
  logic        go, sgn;
  logic [31:0] mag_a, mag_b, q_fix, r_fix;
  logic [32:0] sum, r_sh, diff;
  logic [63:0] step, p_fix;
  assign go    = state == IDLE && bus.start && !bus.op[2];
  assign sgn   = !bus.op[0];
  assign mag_a = sgn && bus.a[31] ? -bus.a : bus.a;
  assign mag_b = sgn && bus.b[31] ? -bus.b : bus.b;
  // acc holds {partial product, multiplier} for MULT and {remainder, quotient/dividend} for DIV
  assign sum   = {1'b0, acc[63:32]} + {1'b0, acc[0] ? m : 32'd0};
  assign r_sh  = acc[63:31];
  assign diff  = r_sh - {1'b0, m};
  assign step  = is_div ? (diff[32] ? {r_sh[31:0], acc[30:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                        : {sum, acc[31:1]};
  assign q_fix = neg_q ? -acc[31:0] : acc[31:0];
  assign r_fix = neg_r ? -acc[63:32] : acc[63:32];
  assign p_fix = neg_q ? -acc : acc;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? CALC : IDLE;
      CALC:    state_nx = cnt == 5'd31 ? FIX : CALC;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= state == FIX;
      if (go) begin
        cnt    <= '0;
        acc    <= {32'd0, bus.op[1] ? mag_a : mag_b};
        m      <= bus.op[1] ? mag_b : mag_a;
        is_div <= bus.op[1];
        neg_q  <= sgn && (bus.a[31] ^ bus.b[31]);
        neg_r  <= sgn && bus.a[31];
      end else if (state == CALC) begin
        acc <= step;
        cnt <= cnt + 5'd1;
      end else if (state == FIX) begin
        // divide by zero: remainder already reconstructs a; quotient is forced to all ones
        bus.hi <= is_div ? r_fix : p_fix[63:32];
        bus.lo <= is_div ? (m == 32'd0 ? 32'hFFFF_FFFF : q_fix) : p_fix[31:0];
      end else if (state == IDLE && bus.start && bus.op == 3'd4) begin
        bus.hi <= bus.a;
      end else if (state == IDLE && bus.start && bus.op == 3'd5) begin
        bus.lo <= bus.a;
      end
    end
endmodule
